mem_bus_initiator: RTL
======================

// Module: mem_bus_initiator
// PURPOSE
//  Processor-side initiator for the tagged unified-memory bus (proc2mem_* / mem2proc_*).
//  - Accepts load/store requests on a valid/ready port and drives the command until the memory accepts it.
//  - Records the tag of every accepted load and matches returning tags to the original requester ID.
//  - Sits between the MEM stage or a fetch unit and the mem model.
// PARAMETERS
//  ID_W             4   width of requester transaction ID
//  MAX_OUTSTANDING  4   max loads in flight awaiting data (1..15)
// PORTS
//  clk               in   1   clock, all state on posedge
//  rst               in   1   asynchronous reset, active-low (0 = reset)
//  req_valid         in   1   request present
//  req_ready         out  1   request accepted when req_valid & req_ready
//  req_cmd           in   2   BUS_LOAD=2'h1, BUS_STORE=2'h2 (2'h0/2'h3 illegal, ignored)
//  req_addr          in   32  byte address
//  req_data          in   32  store data
//  req_id            in   ID_W  requester tag, echoed on rsp_id
//  proc2mem_command  out  2   BUS_NONE=0 / BUS_LOAD=1 / BUS_STORE=2
//  proc2mem_addr     out  32  address of held request
//  proc2mem_data     out  32  store data of held request
//  mem2proc_response in   4   nonzero = command accepted, value = tag; 0 = rejected, retry
//  mem2proc_data     in   32  load data, valid with mem2proc_tag
//  mem2proc_tag      in   4   nonzero = load with this tag completes this cycle
//  rsp_valid         out  1   one-cycle pulse: load data returned
//  rsp_id            out  ID_W  req_id of the completed load
//  rsp_data          out  32  returned load data
//  outstanding       out  4   loads in flight
//  err_tag           out  1   sticky: unknown tag returned, or accept reused a live tag
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; tag table all invalid; outstanding=0; proc2mem_command=BUS_NONE.
//   Reset values of the remaining outputs: proc2mem_addr/data=0, rsp_valid=0, rsp_id=0, rsp_data=0,
//   err_tag=0, req_ready=0. All take effect immediately, even mid-transaction.
//  FSM IDLE/ISSUE:
//   req_ready = (state==IDLE) & (outstanding<MAX_OUTSTANDING); registered state, no comb path from req_valid.
//   IDLE: on req_valid&req_ready with a legal cmd: latch cmd/addr/data/id, go to ISSUE.
//    Illegal cmd: handshake completes, request dropped, stay IDLE.
//   ISSUE: proc2mem_command/addr/data driven from the holding register and held stable.
//    mem2proc_response==0 -> stay in ISSUE and retry next cycle.
//    mem2proc_response!=0 -> accept; go to IDLE next cycle, command returns to BUS_NONE.
//    Accepted load: table[response] <= {valid,id}; outstanding+1.
//    Accepted store: nothing recorded, no rsp.
//   proc2mem_command=BUS_NONE whenever state==IDLE.
//   Throughput: at most 1 request per 2 cycles.
//  Completion:
//   mem2proc_tag!=0 and table[tag] valid -> next cycle rsp_valid=1, rsp_id=table[tag].id,
//    rsp_data=mem2proc_data (registered, 1-cycle latency). Entry invalidated, outstanding-1.
//   mem2proc_tag!=0 and entry invalid -> dropped, no rsp, err_tag<=1.
//   mem2proc_tag==0 -> rsp_valid=0; rsp_id/rsp_data hold their last value.
//  Simultaneous events:
//   Accept and completion in the same cycle: outstanding unchanged (+1-1).
//   Same tag freed and re-allocated in one cycle: free is applied first, then allocate; entry ends valid
//    with the new id; no err.
//   Accept returns a tag already valid (not freed this cycle): entry overwritten, err_tag<=1,
//    outstanding unchanged.
//  Responses return in any order; matching is by tag only. Tag 0 is never stored.
//  Saturation: outstanding never exceeds MAX_OUTSTANDING because req_ready gates on it.
//   Completion while full re-opens req_ready the next cycle.
// TESTING
//  1 Load, addr=0x100, id=3; response=5 in the 1st ISSUE cycle; tag=5 with data=0xDEADBEEF 4 cycles later
//    -> command=LOAD for 1 cycle; rsp_valid pulse 1 cycle after the tag cycle with id=3, data=0xDEADBEEF;
//    outstanding 0->1->0.
//  2 Store, addr=0x40, data=0x12345678; response=0 for 3 cycles, then 7
//    -> command/addr/data stable for 4 cycles, then BUS_NONE; no rsp; outstanding stays 0.
//  3 MAX_OUTSTANDING=4: four loads get tags 1..4, fifth req_valid held
//    -> req_ready=0 until tag 2 returns, then 1 the next cycle; rsp order 2,4,1,3 matches tag return order.
//  4 Load accepted with tag 6 while mem2proc_tag=6 frees an older load (id=1)
//    -> rsp id=1; table[6] holds the new id; outstanding unchanged; err_tag=0.
//  5 mem2proc_tag=9 with no load outstanding -> no rsp_valid; err_tag=1 and stays 1.
//  6 rst=0 during ISSUE with 2 loads in flight -> command=BUS_NONE immediately, outstanding=0, req_ready=0;
//    after release req_ready=1 next cycle.

Source files
------------

// File: rtl/mem_bus_initiator_if.sv
// Request, memory-bus and response signals of the tagged unified-memory bus initiator.
// The master modport is the initiator's view; slave is the requester/memory environment's view.
interface mem_bus_initiator_if #(
    parameter int ID_W = 4
) ();
    // Request port: a transfer happens on a cycle where req_valid & req_ready are both 1;
    // req_cmd/addr/data/id must be stable while req_valid is 1, and req_ready never depends on req_valid.
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_cmd;
    logic [31:0]     req_addr;
    logic [31:0]     req_data;
    logic [ID_W-1:0] req_id;

    logic [1:0]      proc2mem_command;
    logic [31:0]     proc2mem_addr;
    logic [31:0]     proc2mem_data;
    logic [3:0]      mem2proc_response;
    logic [31:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;

    logic            rsp_valid;
    logic [ID_W-1:0] rsp_id;
    logic [31:0]     rsp_data;

    modport master (
        input  req_valid, req_cmd, req_addr, req_data, req_id,
        output req_ready,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        output req_valid, req_cmd, req_addr, req_data, req_id,
        input  req_ready,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mem_bus_initiator.sv
// Processor-side initiator: issues one held load/store until the memory accepts it, then
// tracks accepted loads by bus tag and returns their data tagged with the requester ID.
module mem_bus_initiator #(
    parameter int ID_W            = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_initiator_if.master bus,
    output logic [3:0]          outstanding,
    output logic                err_tag,
    output logic                issue_dbg
);
    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_LOAD  = 2'h1;
    localparam logic [1:0] BUS_STORE = 2'h2;
    localparam logic [3:0] MAX_OUT   = 4'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rst_done;
    logic            req_ready_int;
    logic            take;
    logic            cmd_legal;
    logic            accept;
    logic            alloc;
    logic            free_hit;
    logic            alloc_live;
    logic            bad_tag;
    logic [3:0]      outstanding_nxt;

    logic [1:0]      hold_cmd;
    logic [31:0]     hold_addr;
    logic [31:0]     hold_data;
    logic [ID_W-1:0] hold_id;

    // Entry 0 exists only so the 4-bit tag can index directly; tag 0 never sets it.
    logic [15:0]     tbl_valid;
    logic [ID_W-1:0] tbl_id [16];

    always_comb begin
        req_ready_int = rst_done && (state == IDLE) && (outstanding < MAX_OUT);
        take          = bus.req_valid && req_ready_int;
        cmd_legal     = (bus.req_cmd == BUS_LOAD) || (bus.req_cmd == BUS_STORE);
        accept        = (state == ISSUE) && (bus.mem2proc_response != 4'h0);
        alloc         = accept && (hold_cmd == BUS_LOAD);
        free_hit      = (bus.mem2proc_tag != 4'h0) && tbl_valid[bus.mem2proc_tag];
        bad_tag       = (bus.mem2proc_tag != 4'h0) && !tbl_valid[bus.mem2proc_tag];
        // A tag freed in this same cycle is legitimately reusable.
        alloc_live    = alloc && tbl_valid[bus.mem2proc_response] &&
                        !(free_hit && (bus.mem2proc_tag == bus.mem2proc_response));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take && cmd_legal) state_nxt = ISSUE;
            ISSUE:   if (accept)            state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        outstanding_nxt = outstanding;
        case ({alloc && !alloc_live, free_hit})
            2'b10:   outstanding_nxt = outstanding + 4'd1;
            2'b01:   outstanding_nxt = outstanding - 4'd1;
            default: outstanding_nxt = outstanding;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rst_done    <= 1'b0;
            outstanding <= 4'd0;
            err_tag     <= 1'b0;
        end else begin
            state       <= state_nxt;
            rst_done    <= 1'b1;
            outstanding <= outstanding_nxt;
            if (bad_tag || alloc_live) err_tag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cmd  <= BUS_NONE;
            hold_addr <= 32'h0;
            hold_data <= 32'h0;
            hold_id   <= '0;
        end else if (state == IDLE && take && cmd_legal) begin
            hold_cmd  <= bus.req_cmd;
            hold_addr <= bus.req_addr;
            hold_data <= bus.req_data;
            hold_id   <= bus.req_id;
        end
    end

    // Free is written before allocate so a same-cycle reuse of one tag ends valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_valid <= 16'h0;
        end else begin
            if (free_hit) tbl_valid[bus.mem2proc_tag]      <= 1'b0;
            if (alloc)    tbl_valid[bus.mem2proc_response] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) tbl_id[bus.mem2proc_response] <= hold_id;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= 32'h0;
        end else begin
            bus.rsp_valid <= free_hit;
            if (free_hit) begin
                bus.rsp_id   <= tbl_id[bus.mem2proc_tag];
                bus.rsp_data <= bus.mem2proc_data;
            end
        end
    end

    assign bus.req_ready        = req_ready_int;
    assign bus.proc2mem_command = (state == ISSUE) ? hold_cmd : BUS_NONE;
    assign bus.proc2mem_addr    = hold_addr;
    assign bus.proc2mem_data    = hold_data;
    assign issue_dbg            = (state == ISSUE);

endmodule
